// File: rtl/tia_adc_sequencer_pkg.sv
// tia_pkg: state encoding, TIA gain codes and timing defaults shared by the sequencer files.
package tia_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, CONV, SHIFT, ACCUM, DONE} tia_seq_state_t;
    localparam logic [1:0] TIA_GAIN_1K   = 2'd0;
    localparam logic [1:0] TIA_GAIN_10K  = 2'd1;
    localparam logic [1:0] TIA_GAIN_100K = 2'd2;
    localparam logic [1:0] TIA_GAIN_1M   = 2'd3;
    localparam int DEF_SCLK_DIV    = 4;
    localparam int DEF_CONV_CYCLES = 100;
endpackage

// File: rtl/tia_adc_sequencer_if.sv
// tia_adc_sequencer_if: control fields from the register file and measurement results back to it.
interface tia_adc_sequencer_if #(
    parameter int ADC_BITS = 16,
    parameter int CNT_W    = 8,
    parameter int ACC_W    = 32,
    parameter int SETTLE_W = 16
);
    logic                start;
    logic                abort;
    logic [1:0]          gain_sel;
    logic [SETTLE_W-1:0] settle_cycles;
    logic [CNT_W-1:0]    num_samples;
    logic                busy;
    logic                done;
    logic [ADC_BITS-1:0] result_last;
    logic [ACC_W-1:0]    result_acc;
    logic [CNT_W-1:0]    result_cnt;
    modport master (
        output start, abort, gain_sel, settle_cycles, num_samples,
        input  busy, done, result_last, result_acc, result_cnt
    );
    modport slave (
        input  start, abort, gain_sel, settle_cycles, num_samples,
        output busy, done, result_last, result_acc, result_cnt
    );
endinterface

// File: rtl/tia_spi_rx.sv
// tia_spi_rx: SCLK generator and MSB-first shift register for one ADC readout.
// valid marks the cycle whose closing edge samples the final bit; data holds the full word from the next cycle.
module tia_spi_rx import tia_pkg::*; #(
    parameter int ADC_BITS = 16,
    parameter int SCLK_DIV = DEF_SCLK_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                stop,
    input  logic                sdo,
    output logic                sclk,
    output logic                valid,
    output logic [ADC_BITS-1:0] data
);
    localparam int PW = $clog2(2 * SCLK_DIV);
    localparam int BW = $clog2(ADC_BITS);
    logic          active;
    logic [PW-1:0] phase;
    logic [BW-1:0] bit_idx;
    logic          phase_end;
    assign phase_end = phase == PW'(2 * SCLK_DIV - 1);
    assign valid     = active && phase_end && bit_idx == BW'(ADC_BITS - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            phase   <= '0;
            bit_idx <= '0;
            data    <= '0;
        end else if (go) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            phase   <= '0;
            bit_idx <= '0;
        end else if (active) begin
            phase <= phase_end ? '0 : phase + 1'b1;
            sclk  <= phase == PW'(SCLK_DIV - 1) ? 1'b1 : phase_end ? 1'b0 : sclk;
            // sample at the end of the high phase, just before SCLK falls
            if (phase_end) begin
                data    <= {data[ADC_BITS-2:0], sdo};
                bit_idx <= bit_idx + 1'b1;
                active  <= !valid;
            end
        end
    end
endmodule

// File: rtl/tia_adc_sequencer.sv
// tia_adc_sequencer: sets TIA gain, waits for settling, then runs N SPI ADC conversions and accumulates them.
module tia_adc_sequencer import tia_pkg::*; #(
    parameter int ADC_BITS    = 16,
    parameter int CNT_W       = 8,
    parameter int ACC_W       = 32,
    parameter int SETTLE_W    = 16,
    parameter int SCLK_DIV    = DEF_SCLK_DIV,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    tia_adc_sequencer_if.slave  bus,
    input  logic                adc_sdo,
    output logic [1:0]          tia_gain,
    output logic                adc_cnv,
    output logic                adc_sclk
);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int TW = SETTLE_W > CW ? SETTLE_W : CW;
    tia_seq_state_t      state;
    logic [TW-1:0]       timer;
    logic [CNT_W-1:0]    num_l;
    logic [CNT_W-1:0]    cnt_inc;
    logic [ADC_BITS-1:0] sample;
    logic                go;
    logic                valid;
    assign go      = state == CONV && timer == '0 && !bus.abort;
    assign cnt_inc = bus.result_cnt + 1'b1;
    tia_spi_rx #(.ADC_BITS(ADC_BITS), .SCLK_DIV(SCLK_DIV)) u_rx (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .go(go), .stop(bus.abort),
        .sdo(adc_sdo), .sclk(adc_sclk), .valid(valid), .data(sample)
    );
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state           <= IDLE;
            timer           <= '0;
            num_l           <= '0;
            tia_gain        <= TIA_GAIN_1K;
            adc_cnv         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result_last <= '0;
            bus.result_acc  <= '0;
            bus.result_cnt  <= '0;
        end else if (state != IDLE && bus.abort) begin
            state    <= IDLE;
            adc_cnv  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start && !bus.abort) begin
                    tia_gain       <= bus.gain_sel;
                    num_l          <= bus.num_samples;
                    bus.result_acc <= '0;
                    bus.result_cnt <= '0;
                    bus.busy       <= 1'b1;
                    if (bus.num_samples == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else if (bus.settle_cycles == '0) begin
                        state   <= CONV;
                        adc_cnv <= 1'b1;
                        timer   <= TW'(CONV_CYCLES - 1);
                    end else begin
                        state <= SETTLE;
                        timer <= TW'(bus.settle_cycles) - 1'b1;
                    end
                end
                SETTLE: if (timer == '0) begin
                    state   <= CONV;
                    adc_cnv <= 1'b1;
                    timer   <= TW'(CONV_CYCLES - 1);
                end else timer <= timer - 1'b1;
                CONV: if (go) begin
                    state   <= SHIFT;
                    adc_cnv <= 1'b0;
                end else timer <= timer - 1'b1;
                SHIFT: if (valid) state <= ACCUM;
                ACCUM: begin
                    bus.result_last <= sample;
                    bus.result_acc  <= bus.result_acc + {{(ACC_W-ADC_BITS){sample[ADC_BITS-1]}}, sample};
                    bus.result_cnt  <= cnt_inc;
                    // later samples reuse the original settling, so go straight back to CONV
                    if (cnt_inc == num_l) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state   <= CONV;
                        adc_cnv <= 1'b1;
                        timer   <= TW'(CONV_CYCLES - 1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
